// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: scan codes, modifier bit indices and the key event record shared by the PS/2 keyboard front end.
package ps2_kbd_pkg;
    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    localparam int MOD_SHIFT = 0;
    localparam int MOD_CTRL  = 1;
    localparam int MOD_ALT   = 2;
    localparam int MOD_CAPS  = 3;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic [3:0] mods;
    } ps2_evt_t;

    function automatic logic is_mod_code(input logic [7:0] c);
        return c inside {SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_ALT, SC_CAPS};
    endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises and debounces the PS/2 pins, deserialises 11-bit frames
// and checks start/parity/stop plus a start-to-stop watchdog.
module ps2_frame_rx #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int DEBOUNCE_CLKS = 63,
    parameter int FRAME_TMO_US  = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_out,
    output logic       byte_done,
    output logic       frame_err
);
    localparam int TMO = CLK_HZ / 1_000_000 * FRAME_TMO_US;
    localparam int WW  = $clog2(TMO + 1);
    localparam int DW  = $clog2(DEBOUNCE_CLKS + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_PAR  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic [1:0]    clk_sy, dat_sy;
    logic          clk_f;
    logic [DW-1:0] db_cnt;
    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    sh;
    logic          par;
    logic [WW-1:0] wd;
    logic          stable_hit, fall, d, tmo;

    always_comb begin
        stable_hit = (clk_sy[1] != clk_f) && (db_cnt == DW'(DEBOUNCE_CLKS - 1));
        fall       = stable_hit && !clk_sy[1];
        d          = dat_sy[1];
        tmo        = (state != S_IDLE) && (wd == WW'(TMO - 1));
    end

    // Pins idle high, so the synchronisers and filter reset high to avoid a phantom falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sy    <= 2'b11;
            dat_sy    <= 2'b11;
            clk_f     <= 1'b1;
            db_cnt    <= '0;
            state     <= S_IDLE;
            bit_cnt   <= '0;
            sh        <= '0;
            par       <= 1'b0;
            wd        <= '0;
            byte_out  <= '0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            clk_sy    <= {clk_sy[0], ps2_clk};
            dat_sy    <= {dat_sy[0], ps2_data};
            db_cnt    <= (clk_sy[1] == clk_f || stable_hit) ? '0 : db_cnt + 1'b1;
            if (stable_hit) clk_f <= clk_sy[1];
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            wd        <= (state == S_IDLE) ? '0 : wd + 1'b1;
            if (tmo) begin
                state     <= S_IDLE;
                frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    S_IDLE: if (!d) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                    end
                    S_DATA: begin
                        sh      <= {d, sh[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= S_PAR;
                    end
                    S_PAR: begin
                        par   <= d;
                        state <= S_STOP;
                    end
                    default: begin
                        state <= S_IDLE;
                        if (d && (^sh ^ par)) begin
                            byte_out  <= sh;
                            byte_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/ps2_keyboard_evt_fifo.sv
// ps2_keyboard_evt_fifo: PS/2 keyboard receiver that assembles prefixed scan codes into key events,
// tracks modifier/caps state and buffers events in a first-word-fallthrough FIFO.
module ps2_keyboard_evt_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int DEBOUNCE_CLKS  = 63,
    parameter int FRAME_TMO_US   = 2000,
    parameter int FIFO_DEPTH     = 16,
    parameter int TRAP_MODIFIERS = 1
) (
    input  logic                            sys_clk_0,
    input  logic                            reset_n,
    input  logic                            ps2_clk,
    input  logic                            ps2_data,
    output logic [7:0]                      evt_code,
    output logic                            evt_extended,
    output logic                            evt_released,
    output logic [3:0]                      evt_mods,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            overflow,
    input  logic                            clr_overflow,
    output logic                            frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic [1:0] rst_sy;
    logic       rst_n;
    logic [7:0] rx_byte;
    logic       rx_done, rx_err;

    always_ff @(posedge sys_clk_0 or negedge reset_n) begin
        if (!reset_n) rst_sy <= 2'b00;
        else          rst_sy <= {rst_sy[0], 1'b1};
    end
    assign rst_n = rst_sy[1];

    ps2_frame_rx #(
        .CLK_HZ       (CLK_HZ),
        .DEBOUNCE_CLKS(DEBOUNCE_CLKS),
        .FRAME_TMO_US (FRAME_TMO_US)
    ) u_rx (
        .clk      (sys_clk_0),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .byte_out (rx_byte),
        .byte_done(rx_done),
        .frame_err(rx_err)
    );

    logic     ext_f, rel_f;
    logic     lsh, rsh, lctl, rctl, lalt, ralt, caps_dn, caps;
    logic     lsh_n, rsh_n, lctl_n, rctl_n, lalt_n, ralt_n, caps_dn_n, caps_n;
    logic     is_pre, bad, make;
    logic [3:0] mods_n;
    logic     push_q;
    ps2_evt_t evt_q;

    always_comb begin
        is_pre    = rx_byte inside {SC_E0, SC_E1, SC_F0};
        bad       = (rx_byte == 8'h00) || (rx_byte == 8'hFF);
        make      = !rel_f;
        lsh_n     = (rx_byte == SC_LSHIFT) ? make : lsh;
        rsh_n     = (rx_byte == SC_RSHIFT) ? make : rsh;
        lctl_n    = (rx_byte == SC_CTRL && !ext_f) ? make : lctl;
        rctl_n    = (rx_byte == SC_CTRL && ext_f) ? make : rctl;
        lalt_n    = (rx_byte == SC_ALT && !ext_f) ? make : lalt;
        ralt_n    = (rx_byte == SC_ALT && ext_f) ? make : ralt;
        // Typematic repeats of caps arrive as makes while the key is still down; only the first toggles.
        caps_n    = (rx_byte == SC_CAPS && make && !caps_dn) ? !caps : caps;
        caps_dn_n = (rx_byte == SC_CAPS) ? make : caps_dn;
        mods_n    = 4'b0;
        mods_n[MOD_SHIFT] = lsh_n | rsh_n;
        mods_n[MOD_CTRL]  = lctl_n | rctl_n;
        mods_n[MOD_ALT]   = lalt_n | ralt_n;
        mods_n[MOD_CAPS]  = caps_n;
    end

    always_ff @(posedge sys_clk_0 or negedge rst_n) begin
        if (!rst_n) begin
            {ext_f, rel_f}                      <= 2'b00;
            {lsh, rsh, lctl, rctl, lalt, ralt}  <= 6'b0;
            {caps_dn, caps}                     <= 2'b00;
            push_q                              <= 1'b0;
            evt_q                               <= '0;
            frame_err                           <= 1'b0;
        end else begin
            push_q    <= 1'b0;
            frame_err <= rx_err | (rx_done & bad);
            if (rx_done) begin
                if (is_pre) begin
                    ext_f <= ext_f | (rx_byte != SC_F0);
                    rel_f <= rel_f | (rx_byte == SC_F0);
                end else begin
                    ext_f <= 1'b0;
                    rel_f <= 1'b0;
                    if (!bad) begin
                        {lsh, rsh, lctl, rctl, lalt, ralt} <= {lsh_n, rsh_n, lctl_n, rctl_n, lalt_n, ralt_n};
                        {caps_dn, caps}                    <= {caps_dn_n, caps_n};
                        push_q <= !(TRAP_MODIFIERS != 0 && is_mod_code(rx_byte));
                        evt_q  <= {rx_byte, ext_f, rel_f, mods_n};
                    end
                end
            end
        end
    end

    ps2_evt_t        mem [FIFO_DEPTH];
    ps2_evt_t        head;
    logic [AW-1:0]   wp, rp;
    logic            full, pop, push_ok;

    always_comb begin
        evt_valid = fifo_level != '0;
        full      = fifo_level == LW'(FIFO_DEPTH);
        pop       = evt_valid & evt_ready;
        push_ok   = push_q & (!full | pop);
        head      = evt_valid ? mem[rp] : '0;
    end

    assign {evt_code, evt_extended, evt_released, evt_mods} = head;

    always_ff @(posedge sys_clk_0) begin
        if (push_ok) mem[wp] <= evt_q;
    end

    // A drop sets overflow even when software is clearing it in the same cycle.
    always_ff @(posedge sys_clk_0 or negedge rst_n) begin
        if (!rst_n) begin
            wp         <= '0;
            rp         <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop)     rp <= rp + 1'b1;
            fifo_level <= fifo_level + LW'(push_ok) - LW'(pop);
            overflow   <= (push_q & full & !pop) | (overflow & !clr_overflow);
        end
    end
endmodule
